// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, sticky error flags, control register and interrupt.
// Also holds the uart_tx / uart_rx serial cores that the controller wraps.

module uart_tx #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int FB  = PAYLOAD_BITS + 2;

    logic [FB-1:0] frame;
    logic [31:0]   cyc;
    logic [3:0]    idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
            frame        <= '0;
            cyc          <= '0;
            idx          <= '0;
        end else if (!uart_tx_busy) begin
            if (uart_tx_en) begin
                frame        <= {1'b1, uart_tx_data, 1'b0};
                uart_txd     <= 1'b0;
                uart_tx_busy <= 1'b1;
                cyc          <= '0;
                idx          <= '0;
            end
        end else if (cyc == 32'(CPB - 1)) begin
            cyc <= '0;
            if (idx == 4'(FB - 1)) begin
                uart_tx_busy <= 1'b0;
                uart_txd     <= 1'b1;
            end else begin
                idx      <= idx + 4'd1;
                frame    <= {1'b1, frame[FB-1:1]};
                uart_txd <= frame[1];
            end
        end else begin
            cyc <= cyc + 32'd1;
        end
    end
endmodule

module uart_rx #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t state;
    logic [1:0]  sync;
    logic        prev;
    logic [31:0] cyc;
    logic [3:0]  idx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= R_IDLE;
            sync          <= 2'b11;
            prev          <= 1'b1;
            cyc           <= '0;
            idx           <= '0;
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
        end else begin
            sync          <= {sync[0], uart_rxd};
            prev          <= sync[1];
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            case (state)
                R_IDLE: if (prev && !sync[1] && uart_rx_en) begin
                    state <= R_START;
                    cyc   <= '0;
                end
                // Re-check the start bit half a bit in to reject glitches.
                R_START: if (cyc == 32'(CPB / 2 - 1)) begin
                    cyc   <= '0;
                    idx   <= '0;
                    state <= sync[1] ? R_IDLE : R_DATA;
                end else cyc <= cyc + 32'd1;
                R_DATA: if (cyc == 32'(CPB - 1)) begin
                    cyc          <= '0;
                    uart_rx_data <= PAYLOAD_BITS'({sync[1], uart_rx_data} >> 1);
                    if (idx == 4'(PAYLOAD_BITS - 1)) state <= R_STOP;
                    else idx <= idx + 4'd1;
                end else cyc <= cyc + 32'd1;
                R_STOP: if (cyc == 32'(CPB - 1)) begin
                    cyc   <= '0;
                    state <= R_IDLE;
                    if (sync[1]) uart_rx_valid <= 1'b1;
                    else if (uart_rx_data == '0) uart_rx_break <= 1'b1;
                end else cyc <= cyc + 32'd1;
                default: state <= R_IDLE;
            endcase
        end
    end
endmodule

module uart_mmio_fifo #(
    parameter int          CLK_HZ       = 100_000_000,
    parameter int          BIT_RATE     = 9600,
    parameter int          PAYLOAD_BITS = 8,
    parameter int          TX_DEPTH     = 16,
    parameter int          RX_DEPTH     = 16,
    parameter logic [63:0] BASE_ADDR    = 64'h5000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic        uart_txd,
    input  logic [63:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic        uart_wen,
    input  logic        uart_ren,
    output logic [31:0] uart_rdata,
    output logic        uart_irq,
    output logic [7:0]  led
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} tx_state_t;

    logic [PAYLOAD_BITS-1:0] tx_mem [TX_DEPTH];
    logic [PAYLOAD_BITS-1:0] rx_mem [RX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp, tx_count;
    logic [RAW:0] rx_wp, rx_rp, rx_count;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_busy;
    logic sel_data, sel_status, sel_ctrl, sel_level;
    logic tx_push, tx_pop, rx_push, rx_pop, overrun;
    tx_state_t tx_state;
    logic seen_busy, core_tx_en, core_busy, rx_valid, rx_break;
    logic [PAYLOAD_BITS-1:0] core_tx_data, rx_data;
    logic [2:0]  flags;   // {rx_break, tx_drop, rx_overrun}
    logic [3:0]  ctrl;    // {ie_err, ie_tx, ie_rx, rx_en}
    logic [31:0] read_word;
    logic        unused_wdata;

    assign unused_wdata = ^uart_wdata;
    assign sel_data   = uart_addr == BASE_ADDR;
    assign sel_status = uart_addr == BASE_ADDR + 64'h4;
    assign sel_ctrl   = uart_addr == BASE_ADDR + 64'h8;
    assign sel_level  = uart_addr == BASE_ADDR + 64'hC;

    assign tx_count = tx_wp - tx_rp;
    assign rx_count = rx_wp - rx_rp;
    assign tx_full  = tx_count == (TAW + 1)'(TX_DEPTH);
    assign rx_full  = rx_count == (RAW + 1)'(RX_DEPTH);
    assign tx_empty = tx_count == '0;
    assign rx_empty = rx_count == '0;
    assign tx_busy  = core_busy | ~tx_empty | (tx_state != IDLE);

    // Fullness is judged before any same-cycle drain, so a write to a full TX FIFO always drops.
    assign tx_push = uart_wen & sel_data & ~tx_full;
    assign tx_pop  = (tx_state == IDLE) & ~tx_empty & ~core_busy;
    assign rx_pop  = uart_ren & sel_data & ~rx_empty;
    assign rx_push = rx_valid & ctrl[0] & (~rx_full | rx_pop);
    assign overrun = rx_valid & ctrl[0] & rx_full & ~rx_pop;

    always_comb begin
        read_word = '0;  // NOTE: default first so no path leaves read_word unassigned and infers a latch.
        if (sel_data && !rx_empty) read_word = 32'(rx_mem[rx_rp[RAW-1:0]]);
        else if (sel_status)       read_word = {21'b0, flags, 3'b0, tx_busy, rx_empty, rx_full, tx_empty, tx_full};
        else if (sel_ctrl)         read_word = {28'b0, ctrl};
        else if (sel_level)        read_word = {16'(rx_count), 16'(tx_count)};
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= uart_wdata[PAYLOAD_BITS-1:0];
        if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp        <= '0;
            tx_rp        <= '0;
            rx_wp        <= '0;
            rx_rp        <= '0;
            flags        <= '0;
            ctrl         <= 4'h1;
            uart_rdata   <= '0;
            uart_irq     <= 1'b0;
            led          <= 8'hF0;
            tx_state     <= IDLE;
            seen_busy    <= 1'b0;
            core_tx_en   <= 1'b0;
            core_tx_data <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (uart_ren) uart_rdata <= read_word;
            if (uart_wen && sel_ctrl) ctrl <= uart_wdata[3:0];
            flags <= (flags & ~((uart_wen && sel_status) ? uart_wdata[10:8] : 3'b0))
                   | {rx_break, uart_wen & sel_data & tx_full, overrun};
            if (rx_push)      led <= 8'(rx_data);
            else if (tx_push) led <= 8'(uart_wdata[PAYLOAD_BITS-1:0]);
            uart_irq <= (ctrl[1] & ~rx_empty) | (ctrl[2] & tx_empty & ~tx_busy) | (ctrl[3] & |flags);

            core_tx_en <= 1'b0;
            case (tx_state)
                IDLE: if (tx_pop) begin
                    core_tx_data <= tx_mem[tx_rp[TAW-1:0]];
                    core_tx_en   <= 1'b1;
                    seen_busy    <= 1'b0;
                    tx_state     <= LAUNCH;
                end
                LAUNCH: tx_state <= WAIT;
                // Leave only after the core has gone busy and then idle again.
                WAIT: begin
                    seen_busy <= seen_busy | core_busy;
                    if (seen_busy && !core_busy) tx_state <= IDLE;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    uart_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_tx (
        .clk          (clk),
        .resetn       (~rst),
        .uart_txd     (uart_txd),
        .uart_tx_busy (core_busy),
        .uart_tx_en   (core_tx_en),
        .uart_tx_data (core_tx_data)
    );

    uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_rx (
        .clk           (clk),
        .resetn        (~rst),
        .uart_rxd      (uart_rxd),
        .uart_rx_en    (1'b1),
        .uart_rx_break (rx_break),
        .uart_rx_valid (rx_valid),
        .uart_rx_data  (rx_data)
    );
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Bench for uart_mmio_fifo: directed bus and serial stimulus, checked against queue models
// of the TX byte stream and RX FIFO contents plus hand-computed register values.
`timescale 1ns/1ps
module tb_uart_mmio_fifo;
    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 125_000;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam logic [63:0] BASE    = 64'h5000_0000;
    localparam logic [63:0] A_DATA  = BASE;
    localparam logic [63:0] A_STAT  = BASE + 64'h4;
    localparam logic [63:0] A_CTRL  = BASE + 64'h8;
    localparam logic [63:0] A_LEVEL = BASE + 64'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;
    logic [63:0] uart_addr = '0;
    logic [31:0] uart_wdata = '0;
    logic        uart_wen = 1'b0;
    logic        uart_ren = 1'b0;
    logic [31:0] uart_rdata;
    logic        uart_irq;
    logic [7:0]  led;

    always #5 clk = ~clk;

    uart_mmio_fifo #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8),
        .TX_DEPTH(16), .RX_DEPTH(16), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_wen(uart_wen), .uart_ren(uart_ren),
        .uart_rdata(uart_rdata), .uart_irq(uart_irq), .led(led)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_q[$];
    logic       m_rx_en = 1'b1;
    logic [7:0] led_exp = 8'hF0;
    int rst_gen = 0;
    int frames_started = 0;
    int frames_done = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [31:0] d);
        uart_addr = a; uart_wdata = d; uart_wen = 1'b1;
        @(negedge clk);
        uart_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] a, output logic [31:0] d);
        uart_addr = a; uart_ren = 1'b1;
        @(negedge clk);
        uart_ren = 1'b0;
        d = uart_rdata;
    endtask

    task automatic bus_wr_rd(input logic [63:0] a, input logic [31:0] wd, output logic [31:0] d);
        uart_addr = a; uart_wdata = wd; uart_wen = 1'b1; uart_ren = 1'b1;
        @(negedge clk);
        uart_wen = 1'b0; uart_ren = 1'b0;
        d = uart_rdata;
    endtask

    task automatic tx_write(input logic [7:0] b);
        bus_write(A_DATA, {24'b0, b});
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin uart_rxd = b[i]; tick(CPB); end
        uart_rxd = stop; tick(CPB);
        uart_rxd = 1'b1; tick(4);
    endtask

    // Model of the RX side: enabled bytes are queued until 16 are held, then dropped.
    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
        if (m_rx_en && rx_q.size() < 16) begin
            rx_q.push_back(b);
            led_exp = b;
        end
    endtask

    function automatic logic [31:0] rx_pop_exp();
        if (rx_q.size() == 0) return 32'h0;
        return {24'b0, rx_q.pop_front()};
    endfunction

    task automatic read_data_check(input string name);
        logic [31:0] d, e;
        e = rx_pop_exp();
        bus_read(A_DATA, d);
        check(name, d, e);
    endtask

    task automatic read_check(input string name, input logic [63:0] a, input logic [31:0] e);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, e);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (frames_done < n && c < budget) begin @(negedge clk); c++; end
        check("tx_frames_done", frames_done, n);
    endtask

    // Serial monitor on txd: decode 8N1 frames at mid-bit and compare with the written byte stream.
    initial begin : tx_monitor
        logic [7:0] b;
        int gen;
        forever begin
            @(negedge clk);
            if (!rst && uart_txd === 1'b0) begin
                gen = rst_gen;
                frames_started++;
                tick(CPB / 2);
                for (int i = 0; i < 8; i++) begin tick(CPB); b[i] = uart_txd; end
                tick(CPB);
                if (gen == rst_gen) begin
                    check("tx_stop_bit", {31'b0, uart_txd}, 32'd1);
                    check("tx_byte", {24'b0, b}, (tx_exp.size() != 0) ? {24'b0, tx_exp.pop_front()} : 32'h100);
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] d;
        int fs;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // Reset state.
        check("rst_led", {24'b0, led}, 32'hF0);
        check("rst_irq", {31'b0, uart_irq}, 0);
        check("rst_rdata", uart_rdata, 0);
        check("rst_txd", {31'b0, uart_txd}, 1);
        read_check("rst_status", A_STAT, 32'h0000_000A);
        read_check("rst_ctrl", A_CTRL, 32'h1);
        read_check("rst_level", A_LEVEL, 32'h0);
        read_check("unmapped_read", BASE + 64'h10, 32'h0);

        // Three back-to-back bytes.
        foreach (tx_exp[i]) ;
        tx_exp.push_back(8'h41); tx_exp.push_back(8'h42); tx_exp.push_back(8'h43);
        tx_write(8'h41); tx_write(8'h42); tx_write(8'h43);
        led_exp = 8'h43;
        check("led_tx_write", {24'b0, led}, {24'b0, led_exp});
        bus_read(A_STAT, d);
        check("tx_busy_after_writes", d & 32'h10, 32'h10);
        wait_frames(3, 1000);
        bus_read(A_STAT, d);
        check("tx_busy_through_last_stop", d & 32'h10, 32'h10);
        tick(10);
        read_check("status_after_tx", A_STAT, 32'h0000_000A);

        // Overflow while the core is busy on the first byte.
        tx_write(8'h60); tx_exp.push_back(8'h60);
        tick(4);
        for (int i = 0; i < 17; i++) begin
            tx_write(8'h70 + 8'(i));
            if (i < 16) tx_exp.push_back(8'h70 + 8'(i));
        end
        led_exp = 8'h7F;
        read_check("level_tx_full", A_LEVEL, 32'h0000_0010);
        read_check("status_tx_drop", A_STAT, 32'h0000_0219);
        bus_write(A_STAT, 32'h200);
        read_check("status_drop_cleared", A_STAT, 32'h0000_0019);
        check("led_after_drop", {24'b0, led}, {24'b0, led_exp});
        wait_frames(20, 2500);
        tick(10);

        // Seventeen received bytes with no reads: overrun on the last.
        for (int i = 0; i <= 16; i++) send_byte(8'(i));
        read_check("level_rx_full", A_LEVEL, 32'h0010_0000);
        read_check("status_rx_overrun", A_STAT, 32'h0000_0106);
        check("led_rx_push", {24'b0, led}, {24'b0, led_exp});
        for (int i = 0; i < 16; i++) read_data_check("rx_read");
        read_check("status_rx_drained", A_STAT, 32'h0000_010A);
        read_data_check("rx_read_empty");
        bus_write(A_STAT, 32'h100);
        read_check("status_ovr_cleared", A_STAT, 32'h0000_000A);

        // Receiver disabled: byte vanishes silently.
        bus_write(A_CTRL, 32'h0); m_rx_en = 1'b0;
        send_byte(8'h33);
        read_check("level_rx_disabled", A_LEVEL, 32'h0);
        read_check("status_rx_disabled", A_STAT, 32'h0000_000A);
        check("led_rx_disabled", {24'b0, led}, {24'b0, led_exp});
        bus_write(A_CTRL, 32'h1); m_rx_en = 1'b1;

        // Line break sets the sticky break flag and the error interrupt.
        send_frame(8'h00, 1'b0);
        read_check("status_break", A_STAT, 32'h0000_040A);
        bus_write(A_CTRL, 32'h9);
        tick(1);
        check("irq_err", {31'b0, uart_irq}, 1);
        bus_write(A_STAT, 32'h400);
        tick(1);
        check("irq_err_cleared", {31'b0, uart_irq}, 0);

        // Simultaneous write and read of CTRL returns the pre-write value.
        bus_wr_rd(A_CTRL, 32'h3, d);
        check("ctrl_wr_rd_old", d, 32'h9);
        read_check("ctrl_new", A_CTRL, 32'h3);
        check("irq_rx_idle", {31'b0, uart_irq}, 0);

        // RX interrupt timing: one cycle after the push, falls one cycle after the pop.
        fork
            send_byte(8'h5A);
            begin
                int n = 0;
                while (led !== 8'h5A && n < 200) begin @(negedge clk); n++; end
                check("rx_push_seen", {24'b0, led}, 32'h5A);
                check("irq_at_push", {31'b0, uart_irq}, 0);
                @(negedge clk);
                check("irq_after_push", {31'b0, uart_irq}, 1);
            end
        join
        read_data_check("rx_read_5a");
        check("irq_at_pop", {31'b0, uart_irq}, 1);
        tick(1);
        check("irq_after_pop", {31'b0, uart_irq}, 0);

        // TX interrupt: idle transmitter with ie_tx raises it.
        bus_write(A_CTRL, 32'h5);
        tick(1);
        check("irq_tx_idle", {31'b0, uart_irq}, 1);
        bus_write(A_CTRL, 32'h1);
        tick(1);
        check("irq_tx_off", {31'b0, uart_irq}, 0);

        // Reset in the middle of byte 0x55 with four more queued.
        tx_write(8'h55); tx_write(8'h01); tx_write(8'h02); tx_write(8'h03); tx_write(8'h04);
        tick(18);
        check("txd_low_before_reset", {31'b0, uart_txd}, 0);
        rst = 1'b1; rst_gen++;
        tx_exp.delete(); rx_q.delete();
        tick(1);
        check("txd_after_reset", {31'b0, uart_txd}, 1);
        rst = 1'b0;
        fs = frames_started;
        read_check("level_after_reset", A_LEVEL, 32'h0);
        read_check("status_after_reset", A_STAT, 32'h0000_000A);
        read_check("ctrl_after_reset", A_CTRL, 32'h1);
        check("led_after_reset", {24'b0, led}, 32'hF0);
        tick(300);
        check("no_frames_after_reset", frames_started, fs);
        check("txd_idle_after_reset", {31'b0, uart_txd}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
